ssd_scan_controller: RTL and testbench
======================================

SSD_SCAN_CONTROLLER -- requirements
Module: ssd_scan_controller

Interface
REQ-001 The block SHALL have parameter DIGIT_TICKS, default 100000, giving the clock cycles each digit is driven; legal range is 1 or more.
REQ-002 The block SHALL have parameter BLANK_TICKS, default 2000, giving the all-off clock cycles before each digit (anti-ghosting); legal range is 1 or more.
REQ-003 Port ClkPort, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 Port Reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port value, input, 32 bits: eight hex nibbles; nibble i = value[4i+3:4i] drives digit i.
REQ-006 Port dp, input, 8 bits: decimal-point request per digit; 1 = lit.
REQ-007 Port digit_en, input, 8 bits: per-digit enable; 0 = digit stays dark.
REQ-008 Port load, input, 1 bit: single-cycle request to stage value, dp and digit_en.
REQ-009 Port load_ack, output, 1 bit: one-cycle pulse when staged data becomes the displayed data.
REQ-010 Port frame_start, output, 1 bit: one-cycle pulse at each frame boundary.
REQ-011 Port an, output, 8 bits: active-low anodes; an[i] selects digit i.
REQ-012 Port seg, output, 8 bits: active-low cathodes; seg[6:0] = {g,f,e,d,c,b,a} and seg[7] = decimal point.

Function
REQ-013 The block SHALL hold staging registers (stg_value, stg_dp, stg_en) and a pending flag; on any cycle with load=1, the staging registers SHALL capture the inputs and pending SHALL be set.
REQ-014 The block SHALL hold shadow registers (sh_value, sh_dp, sh_en); only the shadow registers drive the display.
REQ-015 The scan FSM SHALL have states BLANK and DRIVE, a 3-bit digit index d, and a tick counter.
REQ-016 In BLANK, the counter SHALL run 0..BLANK_TICKS-1, then move to DRIVE with the counter at 0.
REQ-017 In DRIVE, the counter SHALL run 0..DIGIT_TICKS-1, then move to BLANK with d incremented modulo 8.
REQ-018 One frame SHALL be exactly 8*(BLANK_TICKS+DIGIT_TICKS) cycles.
REQ-019 The frame boundary SHALL be the transition from DRIVE with d=7 into BLANK with d=0.
REQ-020 On the frame boundary edge, frame_start SHALL be 1 for exactly the next cycle.
REQ-021 On the frame boundary edge, if pending was 1 before that edge: staging SHALL be copied to shadow, pending SHALL be cleared, and load_ack SHALL be 1 for exactly the next cycle.
REQ-022 A load coinciding with the boundary edge while pending=0 SHALL be staged and applied at the following boundary.
REQ-023 A load coinciding with the boundary edge while pending=1 SHALL overwrite staging before the copy, so the new data is applied.
REQ-024 Multiple loads within one frame SHALL produce one load_ack, and the last-loaded data SHALL be displayed.
REQ-025 an and seg SHALL be driven directly from flops and be glitch-free; they SHALL reflect the FSM state registered on the same edge.
REQ-026 In BLANK: an = 8'hFF and seg = 8'hFF.
REQ-027 In DRIVE with sh_en[d]=1: an = ~(8'h01<<d), seg[6:0] = HEX(sh_value nibble d), and seg[7] = ~sh_dp[d].
REQ-028 In DRIVE with sh_en[d]=0: an = 8'hFF and seg = 8'hFF; the timing slot is still consumed.
REQ-029 HEX SHALL map 0-F to: 40, 79, 24, 30, 19, 12, 02, 78, 00, 10, 08, 03, 46, 21, 06, 0E (7-bit hex).
REQ-030 The scan SHALL run continuously, independent of load, with no stalls.

Reset
REQ-031 With Reset=1 at an edge, the next cycle SHALL show: state=BLANK, d=0, counter=0, an=8'hFF, seg=8'hFF, load_ack=0, frame_start=0, pending=0, and all staging and shadow registers = 0.
REQ-032 Reset SHALL take priority over load and over the frame boundary.
REQ-033 A reset mid-frame SHALL discard pending data with no load_ack.
REQ-034 After reset, all digits SHALL stay dark until the first load_ack, because sh_en=0.

Verification (BLANK_TICKS=2, DIGIT_TICKS=4; frame = 48 cycles)
REQ-035 Reset, no load, 200 cycles -> an=8'hFF and seg=8'hFF throughout; frame_start pulses every 48 cycles; load_ack is never 1.
REQ-036 load at cycle 1 with value=32'h01234567, dp=0, en=8'hFF -> load_ack and frame_start high together at the first boundary. Next frame: 2 blank cycles, then an=8'hFE and seg=8'hF8 (digit 7 glyph, dp off) for 4 cycles. Digit 1 then shows an=8'hFD and seg=8'h82.
REQ-037 en=8'h05 loaded -> an only ever takes 8'hFF, 8'hFE or 8'hFB.
REQ-038 value nibble 3 = 8, dp[3]=1 -> during digit 3 drive, an=8'hF7 and seg=8'h00.
REQ-039 Two loads in one frame (value A, then B) -> exactly one load_ack, and B is displayed. A load on the boundary cycle with pending=0 -> ack one frame later.
REQ-040 Reset asserted during DRIVE of digit 4 with a load pending -> next cycle an=8'hFF and seg=8'hFF; no load_ack follows; display stays dark.

Source files
------------

// File: rtl/ssd_scan_controller.sv
// Eight-digit multiplexed seven-segment scanner with blanking gaps before each digit.
// New display data is staged on load and committed to the shadow registers only at a frame boundary.
module ssd_scan_controller #(
    parameter int DIGIT_TICKS = 100000,
    parameter int BLANK_TICKS = 2000
) (
    input  logic        ClkPort,
    input  logic        Reset,
    input  logic [31:0] value,
    input  logic [7:0]  dp,
    input  logic [7:0]  digit_en,
    input  logic        load,
    output logic        load_ack,
    output logic        frame_start,
    output logic [7:0]  an,
    output logic [7:0]  seg,
    output logic [3:0]  dbg_state
);

    localparam int MAXT = (DIGIT_TICKS > BLANK_TICKS) ? DIGIT_TICKS : BLANK_TICKS;
    localparam int CW   = (MAXT > 1) ? $clog2(MAXT) : 1;
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_TICKS - 1);
    localparam logic [CW-1:0] DIGIT_LAST = CW'(DIGIT_TICKS - 1);

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    scan_state_t     state, nxt_state;
    logic [2:0]      d, nxt_d;
    logic [CW-1:0]   cnt, nxt_cnt;
    logic            boundary;

    logic [31:0]     stg_value, sh_value;
    logic [7:0]      stg_dp, sh_dp;
    logic [7:0]      stg_en, sh_en;
    logic            pending;

    logic [7:0]      nxt_an, nxt_seg;
    logic [3:0]      nib;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    // Scan sequencing: BLANK_TICKS dark cycles, then DIGIT_TICKS drive cycles, per digit.
    always_comb begin
        nxt_state = state;
        nxt_d     = d;
        nxt_cnt   = cnt + 1'b1;
        boundary  = 1'b0;
        case (state)
            BLANK: begin
                if (cnt == BLANK_LAST) begin
                    nxt_state = DRIVE;
                    nxt_cnt   = '0;
                end
            end
            DRIVE: begin
                if (cnt == DIGIT_LAST) begin
                    nxt_state = BLANK;
                    nxt_cnt   = '0;
                    nxt_d     = d + 3'd1;
                    boundary  = (d == 3'd7);
                end
            end
            default: begin
                nxt_state = BLANK;
                nxt_cnt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered pins line up with the FSM.
    // Shadow data never changes on an edge that enters DRIVE, so the current shadow is correct here.
    always_comb begin
        nxt_an  = 8'hFF;
        nxt_seg = 8'hFF;
        nib     = sh_value[{nxt_d, 2'b00} +: 4];
        if (nxt_state == DRIVE && sh_en[nxt_d]) begin
            nxt_an  = ~(8'h01 << nxt_d);
            nxt_seg = {~sh_dp[nxt_d], hex7(nib)};
        end
    end

    always_ff @(posedge ClkPort) begin
        if (Reset) begin
            state       <= BLANK;
            d           <= 3'd0;
            cnt         <= '0;
            an          <= 8'hFF;
            seg         <= 8'hFF;
            load_ack    <= 1'b0;
            frame_start <= 1'b0;
            pending     <= 1'b0;
            stg_value   <= '0;
            stg_dp      <= '0;
            stg_en      <= '0;
            sh_value    <= '0;
            sh_dp       <= '0;
            sh_en       <= '0;
        end else begin
            state       <= nxt_state;
            d           <= nxt_d;
            cnt         <= nxt_cnt;
            an          <= nxt_an;
            seg         <= nxt_seg;
            frame_start <= boundary;
            load_ack    <= boundary && pending;

            if (load) begin
                stg_value <= value;
                stg_dp    <= dp;
                stg_en    <= digit_en;
            end

            // A load landing on the commit edge wins over the older staged data.
            if (boundary && pending) begin
                sh_value <= load ? value    : stg_value;
                sh_dp    <= load ? dp       : stg_dp;
                sh_en    <= load ? digit_en : stg_en;
                pending  <= 1'b0;
            end else if (load) begin
                pending  <= 1'b1;
            end
        end
    end

    assign dbg_state = {state, d};

endmodule

// File: tb/tb_ssd_scan_controller.sv
// Randomized bench for ssd_scan_controller: a frame-position model predicts every output cycle,
// a monitor compares DUT outputs against the expected queue on the falling edge.
module tb_ssd_scan_controller;

    localparam int BT    = 2;
    localparam int DT    = 4;
    localparam int SLOT  = BT + DT;
    localparam int FRAME = 8 * SLOT;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] val;
    logic [7:0]  dpv;
    logic [7:0]  env;
    logic        ld;
    logic        load_ack, frame_start;
    logic [7:0]  an, seg;
    logic [3:0]  dbg_state;

    ssd_scan_controller #(.DIGIT_TICKS(DT), .BLANK_TICKS(BT)) dut (
        .ClkPort(clk), .Reset(rst), .value(val), .dp(dpv), .digit_en(env), .load(ld),
        .load_ack(load_ack), .frame_start(frame_start), .an(an), .seg(seg),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    logic [17:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Model: cycles since reset, staged/shown data and the pending flag.
    int          m_t = 0;
    bit          m_pend;
    logic [31:0] m_stg_v, m_sh_v;
    logic [7:0]  m_stg_dp, m_sh_dp, m_stg_en, m_sh_en;

    task automatic model_step();
        bit          bnd, ack;
        int          pos, slot_i, w;
        logic [7:0]  e_an, e_seg;
        logic [3:0]  nb;
        bnd = 0;
        ack = 0;
        if (rst) begin
            m_t = 0; m_pend = 0;
            m_stg_v = 0; m_stg_dp = 0; m_stg_en = 0;
            m_sh_v = 0; m_sh_dp = 0; m_sh_en = 0;
        end else begin
            m_t++;
            bnd = (m_t % FRAME == 0);
            if (ld) begin
                m_stg_v = val; m_stg_dp = dpv; m_stg_en = env;
            end
            if (bnd && m_pend) begin
                m_sh_v = m_stg_v; m_sh_dp = m_stg_dp; m_sh_en = m_stg_en;
                m_pend = 0;
                ack = 1;
            end else if (ld) begin
                m_pend = 1;
            end
        end
        pos    = m_t % FRAME;
        slot_i = pos / SLOT;
        w      = pos % SLOT;
        e_an   = 8'hFF;
        e_seg  = 8'hFF;
        if (w >= BT && m_sh_en[slot_i]) begin
            nb     = m_sh_v[slot_i*4 +: 4];
            e_an   = 8'hFF ^ (8'(1) << slot_i);
            e_seg  = {~m_sh_dp[slot_i], hex_tab[nb]};
        end
        exp_q.push_back({ack, bnd, e_an, e_seg});
    endtask

    task automatic cycle(input logic r, input logic l, input logic [31:0] v,
                         input logic [7:0] p, input logic [7:0] en);
        rst = r; ld = l; val = v; dpv = p; env = en;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, $urandom, 8'($urandom), 8'($urandom));
    endtask

    // Advance until the current cycle sits at frame position p.
    task automatic idle_until(input int p);
        int k;
        k = 0;
        while ((m_t % FRAME) != p && k < 2 * FRAME) begin
            idle(1);
            k++;
        end
        checks++;
        if ((m_t % FRAME) != p) begin
            errors++;
            $display("FAIL align: frame position %0d, required %0d", m_t % FRAME, p);
        end
    endtask

    always @(negedge clk) begin
        logic [17:0] e, a;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a = {load_ack, frame_start, an, seg};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL out t=%0d: ack=%b fs=%b an=%h seg=%h, required ack=%b fs=%b an=%h seg=%h",
                         m_t, a[17], a[16], a[15:8], a[7:0], e[17], e[16], e[15:8], e[7:0]);
            end
        end
    end

    initial begin
        rst = 1'b1; ld = 1'b0; val = '0; dpv = '0; env = '0;
        cycle(1'b1, 1'b0, 32'h0, 8'h0, 8'h0);
        cycle(1'b1, 1'b1, 32'hFFFFFFFF, 8'hFF, 8'hFF);

        // Idle after reset: dark, periodic frame_start, no ack.
        idle(200);

        // Reset, then the reference load on the first cycle after reset.
        cycle(1'b1, 1'b0, 32'h0, 8'h0, 8'h0);
        cycle(1'b0, 1'b1, 32'h01234567, 8'h00, 8'hFF);
        idle(2 * FRAME + 5);

        // Sparse enables and a lit decimal point on an 8 glyph.
        idle_until(3);
        cycle(1'b0, 1'b1, 32'h00008000, 8'h08, 8'h05);
        idle(FRAME + 10);
        idle_until(3);
        cycle(1'b0, 1'b1, 32'h0000_8A5C, 8'h08, 8'h08);
        idle(FRAME + 10);

        // Two loads inside one frame: only the second is shown.
        idle_until(5);
        cycle(1'b0, 1'b1, 32'hAAAAAAAA, 8'h55, 8'hFF);
        idle_until(20);
        cycle(1'b0, 1'b1, 32'hFEDCBA98, 8'hAA, 8'hFF);
        idle(FRAME + 10);

        // Load exactly on the boundary edge with nothing pending: applied a frame later.
        idle_until(FRAME - 1);
        cycle(1'b0, 1'b1, 32'h13579BDF, 8'h0F, 8'hF0);
        idle(2 * FRAME);

        // Boundary load with a load already pending: the newer data is committed.
        idle_until(10);
        cycle(1'b0, 1'b1, 32'h11111111, 8'h00, 8'hFF);
        idle_until(FRAME - 1);
        cycle(1'b0, 1'b1, 32'h2468ACE0, 8'hC3, 8'h7E);
        idle(FRAME + 5);

        // Random loads.
        for (int i = 0; i < 1500; i++)
            cycle(1'b0, ($urandom_range(0, 39) == 0), $urandom, 8'($urandom), 8'($urandom));
        idle(FRAME);

        // Reset during digit 4 drive with a load pending: dark, no ack afterwards.
        idle_until(2);
        cycle(1'b0, 1'b1, 32'h98765432, 8'hFF, 8'hFF);
        idle_until(4 * SLOT + BT + 1);
        cycle(1'b1, 1'b1, 32'hFFFFFFFF, 8'hFF, 8'hFF);
        idle(2 * FRAME + 3);

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
